// File: rtl/ext_bus_responder.sv
// External program/data memory responder for the MCU51 bus: latches the
// multiplexed address on ALE, serves code and XDATA bytes on P0, and
// captures XDATA writes on the WR rising edge.
module ext_bus_responder #(
    parameter int unsigned AW = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ALE,
    input  logic        PSEN,
    input  logic        RD,
    input  logic        WR,
    input  logic [7:0]  P0_in,
    input  logic [7:0]  P2_in,
    input  logic [7:0]  code_data,
    output logic [15:0] code_addr,
    output logic [7:0]  P0_out,
    output logic        P0_oe,
    output logic        bus_err,
    output logic [15:0] fetch_cnt
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1 << AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_VALID,
        S_CODE_DRV,
        S_DATA_DRV,
        S_DATA_WR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   code_addr_q, code_addr_d;
    logic [DATA_W-1:0]   p0_out_q, p0_out_d;
    logic                p0_oe_q, p0_oe_d;
    logic                bus_err_q, bus_err_d;
    logic [ADDR_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ale_dly_q, psen_dly_q, rd_dly_q, wr_dly_q;

    logic [DATA_W-1:0]   xram_q [DEPTH];
    logic                xram_we;

    logic                ale_fall;
    logic                psen_fall, rd_fall, wr_fall;
    logic                psen_rise, rd_rise, wr_rise;
    logic [1:0]          strobe_cnt;
    logic                in_range;
    logic [DATA_W-1:0]   xram_rdata;

    // Strobe edge detection against the previous-cycle copies
    always_comb begin
        ale_fall   = ale_dly_q & ~ALE;
        psen_fall  = psen_dly_q & ~PSEN;
        rd_fall    = rd_dly_q & ~RD;
        wr_fall    = wr_dly_q & ~WR;
        psen_rise  = ~psen_dly_q & PSEN;
        rd_rise    = ~rd_dly_q & RD;
        wr_rise    = ~wr_dly_q & WR;
        strobe_cnt = {1'b0, ~PSEN} + {1'b0, ~RD} + {1'b0, ~WR};
        in_range   = ((addr_q >> AW) == ADDR_W'(0));
        xram_rdata = xram_q[addr_q[AW-1:0]];
    end

    // Next-state and output logic; ALE overrides everything
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        code_addr_d = code_addr_q;
        p0_out_d    = p0_out_q;
        p0_oe_d     = p0_oe_q;
        bus_err_d   = bus_err_q;
        fetch_cnt_d = fetch_cnt_q;
        wdata_d     = wdata_q;
        xram_we     = 1'b0;

        if (ALE) begin
            state_d = S_IDLE;
            p0_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ale_fall) begin
                        addr_d      = {P2_in, P0_in};
                        code_addr_d = {P2_in, P0_in};
                        state_d     = S_ADDR_VALID;
                    end
                end
                S_ADDR_VALID: begin
                    p0_oe_d = 1'b0;
                    if (strobe_cnt == 2'd1) begin
                        if (!PSEN)    state_d = S_CODE_DRV;
                        else if (!RD) state_d = S_DATA_DRV;
                        else          state_d = S_DATA_WR;
                    end else if (strobe_cnt >= 2'd2) begin
                        bus_err_d = 1'b1;
                    end
                end
                S_CODE_DRV: begin
                    if (rd_fall || wr_fall) begin
                        bus_err_d = 1'b1;
                        p0_oe_d   = 1'b0;
                        state_d   = S_IDLE;
                    end else if (psen_rise) begin
                        p0_oe_d     = 1'b0;
                        fetch_cnt_d = fetch_cnt_q + ADDR_W'(1);
                        state_d     = S_IDLE;
                    end else begin
                        p0_out_d = code_data;
                        p0_oe_d  = 1'b1;
                    end
                end
                S_DATA_DRV: begin
                    if (psen_fall || wr_fall) begin
                        bus_err_d = 1'b1;
                        p0_oe_d   = 1'b0;
                        state_d   = S_IDLE;
                    end else if (rd_rise) begin
                        p0_oe_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        p0_out_d = in_range ? xram_rdata : 8'hFF;
                        p0_oe_d  = 1'b1;
                    end
                end
                S_DATA_WR: begin
                    p0_oe_d = 1'b0;
                    if (psen_fall || rd_fall) begin
                        bus_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (wr_rise) begin
                        xram_we = in_range;
                        state_d = S_IDLE;
                    end else if (!WR) begin
                        wdata_d = P0_in;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    p0_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Control and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 16'h0000;
            code_addr_q <= 16'h0000;
            p0_out_q    <= 8'hFF;
            p0_oe_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            fetch_cnt_q <= 16'h0000;
            wdata_q     <= 8'h00;
            ale_dly_q   <= 1'b0;
            psen_dly_q  <= 1'b1;
            rd_dly_q    <= 1'b1;
            wr_dly_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            code_addr_q <= code_addr_d;
            p0_out_q    <= p0_out_d;
            p0_oe_q     <= p0_oe_d;
            bus_err_q   <= bus_err_d;
            fetch_cnt_q <= fetch_cnt_d;
            wdata_q     <= wdata_d;
            ale_dly_q   <= ALE;
            psen_dly_q  <= PSEN;
            rd_dly_q    <= RD;
            wr_dly_q    <= WR;
        end
    end

    // XDATA RAM; contents survive reset, but a write coinciding with reset is dropped
    always_ff @(posedge clk) begin
        if (reset && xram_we) begin
            xram_q[addr_q[AW-1:0]] <= wdata_q;
        end
    end

    assign code_addr = code_addr_q;
    assign P0_out    = p0_out_q;
    assign P0_oe     = p0_oe_q;
    assign bus_err   = bus_err_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: doc/ext_bus_responder.md
# ext_bus_responder

External-bus responder for the MCU51 core: it sits on the far side of the CU's ALE/PSEN/RD/WR strobes and the P0/P2 multiplexed address/data pins. It plays the external program-memory and external-data-memory device. For each bus cycle it:

- latches the 16-bit address on ALE falling;
- drives code bytes onto P0 while PSEN is low;
- drives XDATA RAM bytes while RD is low;
- captures P0 into XDATA RAM on WR rising.

All strobes are generated in the same clock domain as the CU, so the block has no synchronizers.

## Interface
Parameters:
- AW, 8, XDATA RAM address width; the RAM holds 2^AW bytes.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- ALE  input  1  address latch enable, active-high.
- PSEN  input  1  program store enable, active-low.
- RD  input  1  external data read strobe, active-low.
- WR  input  1  external data write strobe, active-low.
- P0_in  input  8  P0 pin value: low address during ALE, write data during WR.
- P2_in  input  8  P2 pin value: high address byte.
- code_data  input  8  byte from the external code ROM at code_addr (combinational ROM).
- code_addr  output  16  latched fetch address presented to the code ROM.
- P0_out  output  8  data driven onto P0.
- P0_oe  output  1  P0 output enable.
- bus_err  output  1  sticky flag for an illegal strobe combination.
- fetch_cnt  output  16  number of completed code fetches; wraps.

## Operation
Each signal X has a registered copy X_d. Edges are detected as follows:
- ALE fall: ALE_d=1 and ALE=0.
- PSEN/RD/WR rise: X_d=0 and X=1.

State machine, with states IDLE, ADDR_VALID, CODE_DRV, DATA_DRV, DATA_WR:

- **ALE priority:** in any state, ALE=1 forces the next state to IDLE and P0_oe to 0. No RAM write occurs in that case.
- **IDLE:** on ALE fall, latch addr={P2_in,P0_in}, set code_addr to addr, and go to ADDR_VALID.
- **ADDR_VALID:** count the active (low) strobes among PSEN/RD/WR.
  - Exactly one strobe low:
    - PSEN → CODE_DRV.
    - RD → DATA_DRV.
    - WR → DATA_WR.
  - Two or more strobes low: set bus_err (sticky), stay in ADDR_VALID, keep P0_oe at 0.
- **CODE_DRV:**
  - Each clock: P0_out<=code_data, P0_oe<=1.
  - On PSEN rise: P0_oe<=0, fetch_cnt<=fetch_cnt+1 (modulo 2^16), go to IDLE.
- **DATA_DRV:**
  - Each clock: P0_oe<=1.
  - If addr[15:AW]==0, P0_out<=xram[addr[AW-1:0]]; otherwise P0_out<=8'hFF.
  - On RD rise: P0_oe<=0, go to IDLE.
- **DATA_WR:**
  - P0_oe stays 0.
  - Each clock with WR=0: wdata<=P0_in.
  - On WR rise: if addr[15:AW]==0, xram[addr[AW-1:0]]<=wdata; otherwise the write is dropped. Go to IDLE.
- **Strobe change during a drive/write state:** if a second strobe falls, set bus_err, drop P0_oe, and go to IDLE. No RAM write occurs.
- **P0_out when not driving:** holds its last value.
- **Reset values:**
  - state IDLE.
  - addr and code_addr 16'h0000.
  - P0_out 8'hFF, P0_oe 0.
  - bus_err 0, fetch_cnt 0.
  - wdata 8'h00; all _d registers 1, except ALE_d, which is 0.
  - XDATA RAM contents are not reset.
- **Reset mid-operation:** all of the above take their reset values on the next edge. A pending write is discarded.

## Timing
- Address capture: code_addr is valid 1 clock after the ALE-fall clock.
- Read latency: P0_oe rises 1 clock after the clock in which the strobe is first sampled low in ADDR_VALID, plus 1 clock for the state transition. The total is 2 clocks from the strobe fall.
- P0_out tracks code_data with 1 clock of latency while in CODE_DRV.
- P0_oe falls on the clock edge at which the strobe is first sampled high.
- RAM write happens on the WR-rise detection edge, using the last P0_in sampled while WR was low.
- fetch_cnt updates on the same edge as the PSEN-rise detection.
- A new bus cycle may begin the clock after IDLE is entered. Back-to-back 12-clock machine cycles, as issued by the CU, need no idle gap.

## Test plan
- **Reset check.** Hold reset=0 for 3 clocks with random strobes. Then: P0_oe=0, P0_out=FF, code_addr=0000, fetch_cnt=0, bus_err=0.
- **Code fetch.** ALE pulse with P2=12, P0=34, then PSEN low for 4 clocks with code_data=74.
  - code_addr=1234.
  - P0_oe=1 and P0_out=74 from 2 clocks after the PSEN fall.
  - After PSEN rises: P0_oe=0, fetch_cnt=1.
- **Write then read back.** Write cycle to address 0055 with P0=A5 during WR. Then a read cycle to 0055 with RD low. P0_out=A5 and P0_oe=1.
- **Out-of-range access.** Write 3C to address 0155 (AW=8); the write is dropped. Reading 0055 afterwards returns its prior value. Reading 0155 returns FF.
- **Illegal strobes.** PSEN and RD low together after ALE: bus_err=1 and P0_oe stays 0. bus_err remains 1 through the next legal fetch, until reset.
- **Reset mid-write.** Assert reset=0 while WR is low with P0=77 at address 0010. No write occurs: a later read of 0010 returns its old value, and P0_oe=0 after reset.
